dsp_addsub_arbiter: RTL and testbench
=====================================

# dsp_addsub_arbiter

Shares the single SB_MAC16-based 32-bit add/subtract unit between two requesters in sail-core: port 0 (ALU) and port 1 (branch/address adder). Each port has a valid/ready request channel and a valid/ready response channel. The block arbitrates requests, drives the shared adder's operand and mode pins combinationally from the granted request, and registers the adder result. The result is held until the owning requester accepts it.

## Interface
- Parameters: none (data width fixed at 32, requester count fixed at 2).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request present on port 0 / port 1.
- req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready = fire).
- req0_a, req0_b / req1_a, req1_b  in  32  operands.
- req0_sub / req1_sub  in  1  0 = a+b, 1 = a−b.
- resp0_valid / resp1_valid  out  1  registered result available for that port.
- resp0_ready / resp1_ready  in  1  requester consumes result.
- resp_result  out  32  registered result, shared by both response ports; meaningful only when the matching respN_valid is high.
- dsp_in1, dsp_in2  out  32  operands to the shared adder.
- dsp_is_sub  out  1  mode pin to the shared adder.
- dsp_out  in  32  combinational adder result.

## Operation
- State machine has two states.
  - IDLE: no result held.
  - HOLD: result register valid, owner = resp_owner (1 bit).
- Grant is computed every cycle from req0_valid, req1_valid and the priority rule (see Configuration). At most one reqN_ready is high per cycle, and only for a valid requester.
- Issue is allowed when state == IDLE, or when state == HOLD and the owner's respN_ready is high this cycle (drain and issue in the same cycle).
- reqN_ready = grantN & issue_allowed.
- dsp_in1/dsp_in2/dsp_is_sub are driven by the granted request's a/b/sub. With no grant they are driven with 0/0/0.
- On request fire:
  - result_reg <= dsp_out; resp_owner <= granted port; state <= HOLD.
  - Wrap-around is modulo 2^32; carry/overflow is not reported.
- On owner response fire with no new request fire: state <= IDLE; result_reg is retained (don't care).
- resp0_valid = (state == HOLD) & (resp_owner == 0); resp1_valid likewise for port 1.
- The non-owner's respN_ready is ignored.
- Requests with valid low have no effect. A requester may drop valid before fire; the arbiter does not latch requests.
- Reset mid-operation: any held result is discarded, state -> IDLE, and priority state returns to its reset value.
- Reset values of outputs:
  - req0_ready = req1_ready = 0 while rst_n is low.
  - resp0_valid = resp1_valid = 0.
  - resp_result = 0.
  - dsp_in1 = dsp_in2 = 0 and dsp_is_sub = 0.

## Timing
- Request-to-response latency: one cycle. A request firing in cycle N gives respN_valid high in N+1, with resp_result = a±b.
- Throughput: one operation per cycle when the owner holds respN_ready high continuously.
- Backpressure: while HOLD and the owner's respN_ready is low, both reqN_ready are 0 and result_reg is stable.
- The operand path is combinational from request inputs through the shared adder to result_reg, a single-cycle path.
- Simultaneous valid on both ports: exactly one fires; the loser's reqN_ready stays 0 and it must hold its request.

## Configuration
- DSP_ARB_ROUND_ROBIN_EN defined:
  - Round-robin arbitration; a 1-bit last_grant register resets to 1, so port 0 wins the first contention.
  - On each fire, last_grant <= granted port.
  - When both ports are valid, the port != last_grant wins.
  - A single valid requester always wins.
- Macro undefined: fixed priority, port 0 always beats port 1. There is no last_grant register; port 1 may starve under continuous port 0 traffic.

## Test plan
- Reset: assert rst_n=0 mid-HOLD, then release -> both resp valid 0, resp_result 0, next request accepted from IDLE in the first cycle after release.
- Single add: port 0 a=0x0000_0005, b=0x0000_0003, sub=0, resp0_ready=1 -> req0_ready=1 in cycle N; resp0_valid=1 in N+1 with resp_result=0x0000_0008; resp1_valid stays 0.
- Wrap and subtract:
  - port 1 a=0xFFFF_FFFF, b=0x0000_0001, sub=0 -> resp_result=0x0000_0000.
  - then a=0x0000_0000, b=0x0000_0001, sub=1 -> 0xFFFF_FFFF.
  - crosses the 16-bit half boundary.
- Backpressure: port 0 fires 10+20, resp0_ready=0 for 3 cycles -> resp0_valid held, resp_result=30 stable, req1_ready=0 despite req1_valid=1. Raise resp0_ready -> port 1 fires in the same cycle, and resp1_valid is high next cycle.
- Contention with DSP_ARB_ROUND_ROBIN_EN: both ports valid for 4 consecutive ops, all responses accepted immediately -> grant order 0,1,0,1, one result per cycle.
- Contention without the macro, same stimulus -> grant order 0,0,0,0; port 1 fires only after req0_valid drops.

Source files
------------

// File: rtl/dsp_addsub_arbiter.sv
// dsp_addsub_arbiter
//
// Lets two requesters share one 32-bit add/subtract unit. Port 0 is the ALU
// and port 1 is the branch/address adder. The block picks one valid request
// per cycle and drives the adder's operand and mode pins from it without a
// register in between. The adder result is captured in a register. That
// register is held until the port that owns it accepts the response. A new
// request may issue in the same cycle the owner drains the old result, which
// gives one operation per cycle.
//
// Configuration macro:
//   DSP_ARB_ROUND_ROBIN_EN  defined   -> round-robin arbitration with a 1-bit
//                                        last_grant register (resets to 1, so
//                                        port 0 wins the first contention)
//                           undefined -> fixed priority, port 0 beats port 1
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   reqN_valid / reqN_ready       request handshake for port N
//   reqN_a, reqN_b, reqN_sub      operands and mode (0 = a+b, 1 = a-b)
//   respN_valid / respN_ready     response handshake for port N
//   resp_result                   registered result shared by both ports
//   dsp_in1, dsp_in2, dsp_is_sub  operands and mode sent to the shared adder
//   dsp_out                       combinational result from the shared adder
module dsp_addsub_arbiter (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_sub,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_sub,

    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_result,

    output logic [31:0] dsp_in1,
    output logic [31:0] dsp_in2,
    output logic        dsp_is_sub,
    input  logic [31:0] dsp_out
);

    typedef enum logic {
        StIdle = 1'b0,
        StHold = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic [31:0] result_q, result_d;

    logic grant0, grant1;
    logic owner_ready;
    logic issue_allowed;
    logic fire;

    // Grants are gated by rst_n. This keeps the ready outputs and the adder
    // pins at 0 for as long as reset is held.
`ifdef DSP_ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;

    always_comb begin
        grant0 = rst_n & req0_valid & (~req1_valid | last_grant_q);
        grant1 = rst_n & req1_valid & (~req0_valid | ~last_grant_q);
    end
`else
    always_comb begin
        grant0 = rst_n & req0_valid;
        grant1 = rst_n & req1_valid & ~req0_valid;
    end
`endif

    always_comb begin
        owner_ready   = owner_q ? resp1_ready : resp0_ready;
        // In HOLD the owner must drain in this cycle before a new op can issue.
        issue_allowed = (state_q == StIdle) | owner_ready;
        req0_ready    = grant0 & issue_allowed;
        req1_ready    = grant1 & issue_allowed;
        fire          = req0_ready | req1_ready;
    end

    // The adder pins follow the granted request even while backpressured.
    // They only matter in a cycle where the request actually fires.
    always_comb begin
        dsp_in1    = 32'd0;
        dsp_in2    = 32'd0;
        dsp_is_sub = 1'b0;
        if (grant0) begin
            dsp_in1    = req0_a;
            dsp_in2    = req0_b;
            dsp_is_sub = req0_sub;
        end else if (grant1) begin
            dsp_in1    = req1_a;
            dsp_in2    = req1_b;
            dsp_is_sub = req1_sub;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        result_d = result_q;
        if (fire) begin
            state_d  = StHold;
            owner_d  = req1_ready;
            result_d = dsp_out;
        end else if ((state_q == StHold) && owner_ready) begin
            state_d = StIdle;
        end
    end

`ifdef DSP_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (fire) begin
            last_grant_d = req1_ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        resp0_valid = (state_q == StHold) & ~owner_q;
        resp1_valid = (state_q == StHold) &  owner_q;
        resp_result = result_q;
    end

endmodule

// File: tb/tb_dsp_addsub_arbiter.sv
// Directed testbench for dsp_addsub_arbiter. Inputs change 1 time unit after
// a rising edge. Ready outputs and adder pins are checked at the falling edge.
// Registered outputs are checked 1 time unit after the next rising edge.
module tb_dsp_addsub_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_sub;
    logic [31:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_sub;
    logic [31:0] req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
    logic [31:0] resp_result;
    logic [31:0] dsp_in1, dsp_in2, dsp_out;
    logic        dsp_is_sub;

    int n_cmp = 0;
    int n_err = 0;
    bit rr;

    dsp_addsub_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_sub    (req0_sub),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_sub    (req1_sub),
        .resp0_valid (resp0_valid),
        .resp0_ready (resp0_ready),
        .resp1_valid (resp1_valid),
        .resp1_ready (resp1_ready),
        .resp_result (resp_result),
        .dsp_in1     (dsp_in1),
        .dsp_in2     (dsp_in2),
        .dsp_is_sub  (dsp_is_sub),
        .dsp_out     (dsp_out)
    );

    // Stand-in for the shared adder hard block.
    assign dsp_out = dsp_is_sub ? (dsp_in1 - dsp_in2) : (dsp_in1 + dsp_in2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef DSP_ARB_ROUND_ROBIN_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        rst_n       = 1'b0;
        req0_valid  = 1'b1;
        req0_a      = 32'h0000_0005;
        req0_b      = 32'h0000_0003;
        req0_sub    = 1'b0;
        req1_valid  = 1'b0;
        req1_a      = 32'd0;
        req1_b      = 32'd0;
        req1_sub    = 1'b0;
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;

        // Reset holds every output at 0, even with a valid request present.
        after_edge();
        @(negedge clk);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_resp0_valid", resp0_valid, 0);
        check("rst_resp1_valid", resp1_valid, 0);
        check("rst_resp_result", resp_result, 0);
        check("rst_dsp_in1", dsp_in1, 0);

        // Single add on port 0: 5 + 3.
        rst_n = 1'b1;
        #1;
        check("add_req0_ready", req0_ready, 1);
        check("add_req1_ready", req1_ready, 0);
        check("add_dsp_in1", dsp_in1, 32'h5);
        check("add_dsp_in2", dsp_in2, 32'h3);
        check("add_dsp_is_sub", dsp_is_sub, 0);
        after_edge();
        check("add_resp0_valid", resp0_valid, 1);
        check("add_resp1_valid", resp1_valid, 0);
        check("add_result", resp_result, 32'h0000_0008);
        req0_valid = 1'b0;
        after_edge();
        check("add_drained", resp0_valid, 0);

        // Wrap on port 1, then subtract back across zero.
        req1_valid = 1'b1;
        req1_a     = 32'hFFFF_FFFF;
        req1_b     = 32'h0000_0001;
        req1_sub   = 1'b0;
        @(negedge clk);
        check("wrap_req1_ready", req1_ready, 1);
        after_edge();
        check("wrap_resp1_valid", resp1_valid, 1);
        check("wrap_result", resp_result, 32'h0000_0000);
        req1_a   = 32'h0000_0000;
        req1_b   = 32'h0000_0001;
        req1_sub = 1'b1;
        @(negedge clk);
        check("sub_req1_ready", req1_ready, 1);
        check("sub_dsp_is_sub", dsp_is_sub, 1);
        after_edge();
        check("sub_resp1_valid", resp1_valid, 1);
        check("sub_result", resp_result, 32'hFFFF_FFFF);
        req1_valid = 1'b0;
        after_edge();
        check("sub_drained", resp1_valid, 0);

        // Backpressure: port 0 computes 10 + 20 and holds it while resp0_ready is low.
        resp0_ready = 1'b0;
        req0_valid  = 1'b1;
        req0_a      = 32'd10;
        req0_b      = 32'd20;
        req0_sub    = 1'b0;
        @(negedge clk);
        check("bp_req0_ready", req0_ready, 1);
        after_edge();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_a     = 32'd7;
        req1_b     = 32'd2;
        req1_sub   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_req1_ready", req1_ready, 0);
            check("bp_resp0_valid", resp0_valid, 1);
            check("bp_result", resp_result, 32'd30);
            after_edge();
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        check("bp_release_req1_ready", req1_ready, 1);
        after_edge();
        check("bp_resp1_valid", resp1_valid, 1);
        check("bp_resp0_valid_low", resp0_valid, 0);
        check("bp_result2", resp_result, 32'd5);
        req1_valid = 1'b0;
        after_edge();
        check("bp_drained", resp1_valid, 0);

        // Assert reset while a result is held, then issue in the first cycle after release.
        resp0_ready = 1'b0;
        req0_valid  = 1'b1;
        req0_a      = 32'd1;
        req0_b      = 32'd1;
        after_edge();
        check("mid_hold_valid", resp0_valid, 1);
        req0_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("mid_rst_resp0_valid", resp0_valid, 0);
        check("mid_rst_result", resp_result, 0);
        @(negedge clk);
        rst_n       = 1'b1;
        resp0_ready = 1'b1;
        req1_valid  = 1'b1;
        req1_a      = 32'd4;
        req1_b      = 32'd4;
        req1_sub    = 1'b0;
        #1;
        check("post_rst_req1_ready", req1_ready, 1);
        after_edge();
        check("post_rst_resp1_valid", resp1_valid, 1);
        check("post_rst_result", resp_result, 32'd8);

        // Contention over four back-to-back operations.
        req0_valid = 1'b1;
        req0_a     = 32'd100;
        req0_b     = 32'd1;
        req0_sub   = 1'b0;
        req1_a     = 32'd200;
        req1_b     = 32'd2;
        for (int i = 0; i < 4; i++) begin
            logic g1;
            g1 = rr ? logic'(i % 2) : 1'b0;
            @(negedge clk);
            check("cont_req0_ready", req0_ready, !g1);
            check("cont_req1_ready", req1_ready, g1);
            after_edge();
            check("cont_resp1_valid", resp1_valid, g1);
            check("cont_result", resp_result, g1 ? 32'd202 : 32'd101);
        end
        // With port 0 gone, port 1 is served.
        req0_valid = 1'b0;
        @(negedge clk);
        check("tail_req1_ready", req1_ready, 1);
        after_edge();
        check("tail_resp1_valid", resp1_valid, 1);
        check("tail_result", resp_result, 32'd202);
        req1_valid = 1'b0;
        after_edge();
        check("tail_drained", resp1_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
